// File: rtl/load_store_memory_pkg.sv
// Shared definitions for the load/store memory and the core's load/store decode:
// MIPS-style size codes, the request FSM state type and a size legality helper.
package load_store_memory_pkg;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } lsm_state_t;

    function automatic logic size_legal(input logic [2:0] sz);
        logic ok;
        case (sz)
            SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/load_store_memory_load_align.sv
// Load result formatter: picks the addressed byte/half out of a memory word
// and sign- or zero-extends it according to the size code.
module load_align
    import load_store_memory_pkg::*;
(
    input  logic [31:0] rdword,
    input  logic [1:0]  lane,
    input  logic [2:0]  size,
    output logic [31:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension; illegal sizes format to zero.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        result = 32'h0000_0000;
        case (lane)
            2'd0:    byte_s = rdword[7:0];
            2'd1:    byte_s = rdword[15:8];
            2'd2:    byte_s = rdword[23:16];
            2'd3:    byte_s = rdword[31:24];
            default: byte_s = 8'h00;
        endcase
        if (lane[1]) begin
            half_s = rdword[31:16];
        end else begin
            half_s = rdword[15:0];
        end
        case (size)
            SZ_B:    result = {{24{byte_s[7]}}, byte_s};
            SZ_BU:   result = {24'h000000, byte_s};
            SZ_H:    result = {{16{half_s[15]}}, half_s};
            SZ_HU:   result = {16'h0000, half_s};
            SZ_W:    result = rdword;
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_memory.sv
// Single-outstanding load/store data memory with fixed read latency,
// little-endian byte lanes and error reporting for bad requests.
module load_store_memory
    import load_store_memory_pkg::*;
#(
    parameter int DEPTH_WORDS  = 256,
    parameter int READ_LATENCY = 1
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY - 1);

    // Contents survive reset; the boot image lives entirely in lane 0.
    logic [7:0] mem_b0_q [DEPTH_WORDS] = '{0: 8'd4, 1: 8'd5, 7: 8'd21, default: 8'd0};
    logic [7:0] mem_b1_q [DEPTH_WORDS] = '{default: 8'd0};
    logic [7:0] mem_b2_q [DEPTH_WORDS] = '{default: 8'd0};
    logic [7:0] mem_b3_q [DEPTH_WORDS] = '{default: 8'd0};

    lsm_state_t  state_q;
    logic [1:0]  cnt_q;
    logic        ready_q;
    logic        resp_valid_q;
    logic        resp_error_q;
    logic [31:0] resp_rdata_q;
    logic        hold_error_q;
    logic [31:0] hold_rdata_q;

    logic            accept_s;
    logic [AW-1:0]   idx_s;
    logic            misalign_s;
    logic            range_err_s;
    logic            err_s;
    logic [3:0]      be_s;
    logic [31:0]     wlane_s;
    logic [31:0]     rdword_s;
    logic [31:0]     align_s;
    logic [31:0]     load_data_s;

    assign accept_s    = req_valid && ready_q;
    assign idx_s       = req_addr[AW+1:2];
    assign range_err_s = ((req_addr >> (AW + 2)) != 32'd0);
    assign err_s       = misalign_s || range_err_s || !size_legal(req_size);
    assign rdword_s    = {mem_b3_q[idx_s], mem_b2_q[idx_s], mem_b1_q[idx_s], mem_b0_q[idx_s]};
    assign load_data_s = (req_write || err_s) ? 32'h0000_0000 : align_s;

    // Per-size byte enables, replicated store data and alignment check.
    always_comb begin
        misalign_s = 1'b0;
        be_s       = 4'b0000;
        wlane_s    = 32'h0000_0000;
        case (req_size)
            SZ_B, SZ_BU: begin
                be_s    = 4'b0001 << req_addr[1:0];
                wlane_s = {4{req_wdata[7:0]}};
            end
            SZ_H, SZ_HU: begin
                misalign_s = req_addr[0];
                be_s       = req_addr[1] ? 4'b1100 : 4'b0011;
                wlane_s    = {2{req_wdata[15:0]}};
            end
            SZ_W: begin
                misalign_s = (req_addr[1:0] != 2'b00);
                be_s       = 4'b1111;
                wlane_s    = req_wdata;
            end
            default: begin
                misalign_s = 1'b0;
                be_s       = 4'b0000;
                wlane_s    = 32'h0000_0000;
            end
        endcase
    end

    load_align u_load_align (
        .rdword (rdword_s),
        .lane   (req_addr[1:0]),
        .size   (req_size),
        .result (align_s)
    );

    // Stores commit on the accept edge so a following load sees them.
    always_ff @(posedge clock) begin
        if (accept_s && req_write && !err_s) begin
            if (be_s[0]) mem_b0_q[idx_s] <= wlane_s[7:0];
            if (be_s[1]) mem_b1_q[idx_s] <= wlane_s[15:8];
            if (be_s[2]) mem_b2_q[idx_s] <= wlane_s[23:16];
            if (be_s[3]) mem_b3_q[idx_s] <= wlane_s[31:24];
        end
    end

    // Request FSM with registered handshake and response outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            hold_error_q <= 1'b0;
            hold_rdata_q <= 32'h0000_0000;
        end else begin
            resp_valid_q <= 1'b0;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'h0000_0000;
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        ready_q      <= 1'b0;
                        hold_error_q <= err_s;
                        hold_rdata_q <= load_data_s;
                        if (READ_LATENCY == 1) begin
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_error_q <= err_s;
                            resp_rdata_q <= load_data_s;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= 2'd1;
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == LAST_CNT) begin
                        state_q      <= RESP;
                        cnt_q        <= 2'd0;
                        resp_valid_q <= 1'b1;
                        resp_error_q <= hold_error_q;
                        resp_rdata_q <= hold_rdata_q;
                    end else begin
                        cnt_q <= cnt_q + 2'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 2'd0;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign req_ready  = ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_memory.sv
// Directed plus randomized bench for load_store_memory against a byte-array model.
module tb_load_store_memory;

    localparam int DEPTH = 256;
    localparam int LAT   = 3;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_rdata;
    logic [7:0]  mem_m [0:DEPTH*4-1];

    load_store_memory #(.DEPTH_WORDS(DEPTH), .READ_LATENCY(LAT)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_error (resp_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [2:0] sz, input logic [31:0] a);
        if (a >= 32'(DEPTH * 4)) return 1'b1;
        case (sz)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (a % 2) != 0;
            3'd2:       return (a % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] sz, input logic [31:0] a);
        byte     b;
        shortint h;
        b = mem_m[a];
        case (sz)
            3'd0: return 32'(int'(b));
            3'd4: return 32'(mem_m[a]);
            3'd1: begin h = {mem_m[a+1], mem_m[a]}; return 32'(int'(h)); end
            3'd5: return {16'h0000, mem_m[a+1], mem_m[a]};
            3'd2: return {mem_m[a+3], mem_m[a+2], mem_m[a+1], mem_m[a]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_store(input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
        int nbytes;
        nbytes = (sz == 3'd2) ? 4 : ((sz[1:0] == 2'd1) ? 2 : 1);
        for (int i = 0; i < nbytes; i++) mem_m[a + 32'(i)] = 8'(wd >> (8 * i));
    endtask

    task automatic xact(input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
        int          n;
        logic        e;
        logic [31:0] exp_d;
        req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
        check({tag, ":ready"}, 32'(n < 20), 32'd1);
        e     = model_err(sz, a);
        exp_d = (w || e) ? 32'd0 : model_load(sz, a);
        if (w && !e) model_store(sz, a, wd);
        @(posedge clock); #1;
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_size  = 3'($urandom_range(0, 7));
        req_addr  = $urandom;
        req_wdata = $urandom;
        n = 1;
        while (resp_valid !== 1'b1 && n < 20) begin @(posedge clock); #1; n++; end
        check({tag, ":latency"}, 32'(n), 32'(LAT));
        check({tag, ":error"}, 32'(resp_error), 32'(e));
        check({tag, ":rdata"}, resp_rdata, exp_d);
        last_rdata = resp_rdata;
        @(posedge clock); #1;
        check({tag, ":one_pulse"}, 32'(resp_valid), 32'd0);
    endtask

    task automatic rst_mid(input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input string tag);
        int pulses;
        check({tag, ":ready_pre"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
        if (w && !model_err(sz, a)) model_store(sz, a, wd);
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        check({tag, ":rst_valid"}, 32'(resp_valid), 32'd0);
        check({tag, ":rst_ready"}, 32'(req_ready), 32'd1);
        check({tag, ":rst_rdata"}, resp_rdata, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        check({tag, ":ready_after"}, 32'(req_ready), 32'd1);
        pulses = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (resp_valid === 1'b1) pulses++;
        end
        check({tag, ":no_pulse"}, 32'(pulses), 32'd0);
    endtask

    initial begin
        int          accepts;
        int          pulses;
        int          low;
        logic        prev_r;
        logic        w;
        logic [2:0]  sz;
        logic [31:0] a;

        for (int i = 0; i < DEPTH * 4; i++) mem_m[i] = 8'h00;
        mem_m[0]  = 8'd4;
        mem_m[4]  = 8'd5;
        mem_m[28] = 8'd21;

        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0;
        req_size = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
        @(posedge clock); @(posedge clock); #1;
        check("reset:valid", 32'(resp_valid), 32'd0);
        check("reset:error", 32'(resp_error), 32'd0);
        check("reset:rdata", resp_rdata, 32'd0);
        check("reset:ready", 32'(req_ready), 32'd1);
        reset_n = 1'b1;
        check("reset:ready_first", 32'(req_ready), 32'd1);

        xact(1'b0, 3'd2, 32'h1C, 32'd0, "lw_1c");
        check("lw_1c:const", last_rdata, 32'h0000_0015);
        xact(1'b0, 3'd2, 32'h00, 32'd0, "lw_00");
        check("lw_00:const", last_rdata, 32'h0000_0004);
        xact(1'b0, 3'd2, 32'h04, 32'd0, "lw_04");
        check("lw_04:const", last_rdata, 32'h0000_0005);

        xact(1'b1, 3'd2, 32'h40, 32'h8081F2F3, "sw_40");
        xact(1'b0, 3'd0, 32'h41, 32'd0, "lb_41");
        check("lb_41:const", last_rdata, 32'hFFFF_FFF2);
        xact(1'b0, 3'd4, 32'h43, 32'd0, "lbu_43");
        check("lbu_43:const", last_rdata, 32'h0000_0080);
        xact(1'b0, 3'd1, 32'h42, 32'd0, "lh_42");
        check("lh_42:const", last_rdata, 32'hFFFF_8081);
        xact(1'b0, 3'd5, 32'h40, 32'd0, "lhu_40");
        check("lhu_40:const", last_rdata, 32'h0000_F2F3);

        xact(1'b1, 3'd2, 32'h44, 32'h11223344, "sw_44");
        xact(1'b1, 3'd0, 32'h45, 32'h000000AA, "sb_45");
        xact(1'b0, 3'd2, 32'h44, 32'd0, "lw_44");
        check("lw_44:const", last_rdata, 32'h1122_AA44);

        xact(1'b0, 3'd2, 32'h42, 32'd0, "lw_42_mis");
        xact(1'b1, 3'd1, 32'h43, 32'h0000BEEF, "sh_43_mis");
        xact(1'b1, 3'd2, 32'(DEPTH * 4), 32'hFFFFFFFF, "sw_oor");
        xact(1'b0, 3'd2, 32'(DEPTH * 4), 32'd0, "lw_oor");
        xact(1'b1, 3'd3, 32'h40, 32'hFFFFFFFF, "sw_badsize");
        xact(1'b0, 3'd2, 32'h40, 32'd0, "rb_40");
        check("rb_40:const", last_rdata, 32'h8081_F2F3);
        xact(1'b0, 3'd2, 32'h00, 32'd0, "rb_00");
        check("rb_00:const", last_rdata, 32'h0000_0004);

        // Back-to-back loads with req_valid held high throughout.
        req_valid = 1'b1; req_write = 1'b0; req_size = 3'd2; req_addr = 32'h1C;
        prev_r = req_ready; accepts = 0; pulses = 0; low = 0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clock); #1;
            if (prev_r) accepts++;
            if (resp_valid === 1'b1) begin
                pulses++;
                check("burst:rdata", resp_rdata, 32'h0000_0015);
            end
            if (req_ready !== 1'b1) begin
                low++;
            end else if (low != 0) begin
                check("burst:low_run", 32'(low), 32'd3);
                low = 0;
            end
            prev_r = req_ready;
        end
        req_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clock); #1;
            if (resp_valid === 1'b1) pulses++;
        end
        check("burst:accepts", 32'(accepts), 32'd4);
        check("burst:pulses", 32'(pulses), 32'(accepts));

        rst_mid(1'b0, 3'd2, 32'h1C, 32'd0, "rst_load");
        xact(1'b0, 3'd2, 32'h1C, 32'd0, "post_rst_lw");
        check("post_rst_lw:const", last_rdata, 32'h0000_0015);
        rst_mid(1'b1, 3'd2, 32'h60, 32'hDEADBEEF, "rst_store");
        xact(1'b0, 3'd2, 32'h60, 32'd0, "post_rst_rb");
        check("post_rst_rb:const", last_rdata, 32'hDEAD_BEEF);

        for (int t = 0; t < 60; t++) begin
            w  = 1'($urandom_range(0, 1));
            sz = 3'($urandom_range(0, 7));
            if ((sz == 3'd3 || sz >= 3'd6) && $urandom_range(0, 3) != 0) sz = 3'd2;
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(10, 31));
            xact(w, sz, a, $urandom, "rand");
        end

        for (int i = 0; i < 32; i++) xact(1'b0, 3'd2, 32'(i * 4), 32'd0, "readback");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/load_store_memory.md
LOAD_STORE_MEMORY -- requirements
Module: load_store_memory

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words (power of two, minimum 4).
REQ-002 SHALL have parameter READ_LATENCY, default 1, meaning the cycles from request accept to response (legal values 1..4).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1 bit: request present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 3 bits: MIPS-style size code. 000 = byte signed, 001 = half signed, 010 = word, 100 = byte unsigned, 101 = half unsigned; other codes are illegal.
REQ-009 SHALL have port req_addr, input, 32 bits: byte address.
REQ-010 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle response pulse.
REQ-012 SHALL have port resp_rdata, output, 32 bits: load result, extended to 32 bits; zero for stores and errors.
REQ-013 SHALL have port resp_error, output, 1 bit: misaligned, out-of-range or illegal-size request; valid with resp_valid.

Function
REQ-014 A request SHALL be accepted on a rising edge where req_valid and req_ready are both 1.
REQ-015 The FSM SHALL have three states: IDLE, WAIT and RESP.
- IDLE → WAIT on accept when READ_LATENCY > 1.
- IDLE → RESP on accept when READ_LATENCY = 1.
- WAIT → RESP when the latency counter reaches READ_LATENCY-1.
- RESP → IDLE unconditionally.
REQ-016 req_ready SHALL be 1 only in IDLE; only one request is outstanding at a time.
REQ-017 resp_valid SHALL be 1 only in RESP, for exactly one cycle, READ_LATENCY cycles after accept; there is no response backpressure.
REQ-018 On accept, the block SHALL register the request's write flag, size, address and data; later changes on the req_* inputs SHALL have no effect.
REQ-019 Word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]; byte lane SHALL be req_addr[1:0].
REQ-020 Misalignment is defined as: a half access with addr[0] = 1, or a word access with addr[1:0] ≠ 00.
REQ-021 Out of range is defined as: any of addr[31:log2(DEPTH_WORDS)+2] nonzero.
REQ-022 An erroring request SHALL leave memory unchanged, and its response SHALL carry resp_error = 1 and resp_rdata = 0.
REQ-023 A legal store SHALL update only the addressed bytes, at the accept edge, little-endian:
- byte: lane addr[1:0] = wdata[7:0];
- half: lanes addr[1]*2 and +1 = wdata[15:0];
- word: all four lanes.
REQ-024 A legal load SHALL sample memory at the accept edge, select the bytes per REQ-023, and sign- or zero-extend them per req_size.
REQ-025 A load accepted immediately after a store to the same word SHALL return the stored value.
REQ-026 A store SHALL respond with resp_error as defined above and resp_rdata = 0.

Reset
REQ-027 reset_n low SHALL immediately force the FSM to IDLE, clear the latency counter, and drive resp_valid = 0, resp_error = 0 and resp_rdata = 0.
REQ-028 Reset asserted mid-operation SHALL discard the outstanding response.
- A store already committed at its accept edge SHALL remain in memory.
- No response pulse SHALL appear after reset is released.
REQ-029 Reset SHALL NOT clear memory contents; word 0 = 4, word 1 = 5 and word 7 = 21 SHALL be preloaded at time zero, all other words 0.
REQ-030 req_ready SHALL be 1 during reset and in the first cycle after reset deassertion.

Structure
REQ-031 A shared package SHALL hold the size-code constants (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and the FSM state typedef; the MIPS core decode SHALL reuse them.
REQ-032 The byte select and extend logic SHALL be one combinational sub-module, load_align, with inputs rdword, lane and size, and output result.
REQ-033 Storage SHALL be four byte-wide arrays (one per lane) of DEPTH_WORDS entries each.

Verification
REQ-034 After reset, a load of word at addr 0x1C -> resp_rdata = 0x00000015 and resp_error = 0, exactly READ_LATENCY cycles after accept.
REQ-035 Store word 0x8081F2F3 at 0x40, then:
- LB at 0x41 -> 0xFFFFFFF2;
- LBU at 0x43 -> 0x00000080;
- LH at 0x42 -> 0xFFFF8081;
- LHU at 0x40 -> 0x0000F2F3.
REQ-036 SB of 0x000000AA at 0x45 onto word 0x11223344, then LW at 0x44 -> 0x1122AA44.
REQ-037 LW at 0x42, SH at 0x43 and an access at byte address DEPTH_WORDS*4 -> resp_error = 1, resp_rdata = 0, and memory unchanged (verified by readback).
REQ-038 With READ_LATENCY = 3: req_valid held high continuously -> req_ready low for 3 cycles after each accept, with exactly one resp_valid pulse per request.
REQ-039 reset_n pulsed low one cycle after a load is accepted -> no resp_valid pulse, FSM in IDLE, and a subsequent request is served normally.
